// File: rtl/scan_sel.sv
// scan_sel: debounced up/down selector for the VGA mode/scan logic.
// Every raw request line is synchronised and debounced, and its rising edge
// is detected. The W-bit selector then steps up on any advance line or down
// on the retreat line. It either wraps or saturates at 0 and MAX, and it
// produces a binary value, a one-hot decode and a one-cycle change strobe.
module scan_sel #(
  parameter int N_IN      = 2,
  parameter int W         = 2,
  parameter int MAX       = 3,
  parameter int DB_CYCLES = 4,
  parameter int WRAP      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] en_in,
  input  logic            dec_in,
  output logic [W-1:0]    sdata,
  output logic [MAX:0]    sel_oh,
  output logic            step
);

  // Line N_IN is the retreat line; lines 0..N_IN-1 are the advance lines.
  localparam int           NL       = N_IN + 1;
  localparam logic [7:0]   CNT_LAST = 8'(DB_CYCLES - 1);
  localparam logic [W-1:0] MAX_V    = W'(MAX);
  localparam logic [MAX:0] OH_RST   = (MAX + 1)'(1);

  logic [NL-1:0]      raw;
  logic [NL-1:0]      sync1_q, sync2_q;
  logic [NL-1:0]      db_q, db_d;
  logic [NL-1:0][7:0] cnt_q, cnt_d;
  logic [NL-1:0]      rise_q, rise_d;
  logic               inc_req, dec_req;
  logic [W-1:0]       sdata_q, sdata_d;
  logic [MAX:0]       sel_oh_q, sel_oh_d;
  logic               step_q, step_d;

  assign raw = {dec_in, en_in};

  // Two-flop synchroniser for every raw line.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so that every flop samples the pre-edge values.
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce. A line's level is accepted after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < NL; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
    rise_d = db_d & ~db_q;
  end

  // Debounced levels, counters and registered rising-edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q   <= '0;
      cnt_q  <= '0;
      rise_q <= '0;
    end else begin
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  // Merge the rise pulses into one increment request and one decrement request.
  always_comb begin
    inc_req = |rise_q[N_IN-1:0];
    dec_req = rise_q[N_IN];
  end

  // Next selector value. Limits are compared explicitly, so a non-power-of-two MAX stays in range.
  always_comb begin
    sdata_d = sdata_q;
    if (inc_req && !dec_req) begin
      if (sdata_q == MAX_V) begin
        sdata_d = (WRAP != 0) ? '0 : sdata_q;
      end else begin
        sdata_d = sdata_q + W'(1);
      end
    end else if (dec_req && !inc_req) begin
      if (sdata_q == '0) begin
        sdata_d = (WRAP != 0) ? MAX_V : sdata_q;
      end else begin
        sdata_d = sdata_q - W'(1);
      end
    end
    step_d = (sdata_d != sdata_q);
    for (int k = 0; k <= MAX; k++) begin
      sel_oh_d[k] = (sdata_d == W'(k));
    end
  end

  // Selector, decode and change strobe. All three are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdata_q  <= '0;
      sel_oh_q <= OH_RST;
      step_q   <= 1'b0;
    end else begin
      sdata_q  <= sdata_d;
      sel_oh_q <= sel_oh_d;
      step_q   <= step_d;
    end
  end

  assign sdata  = sdata_q;
  assign sel_oh = sel_oh_q;
  assign step   = step_q;

endmodule

// File: doc/scan_sel.md
Name: scan_sel

Overview:
- Synchronous, parametrised successor to the display scan/mode selector.
- Takes N_IN raw asynchronous "advance" request lines and one raw "retreat" line, typically from buttons or pulse sources.
- Synchronises and debounces every line, detects rising edges, and steps a W-bit selector up or down with configurable wrap or saturate.
- Drives the binary selector, a one-hot decode and a one-cycle change strobe to the VGA mode/scan logic.

Parameters:
N_IN, 2, number of advance request lines; any of them causes an increment.
W, 2, width of the binary selector output.
MAX, 3, highest selector value; legal range 1..2^W-1.
DB_CYCLES, 4, consecutive stable synchronised cycles required to accept a level change; legal range 1..255.
WRAP, 1, 1 = wrap MAX<->0; 0 = saturate at 0 and MAX.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en_in  input  N_IN  raw asynchronous advance requests, level, active-high
dec_in  input  1  raw asynchronous retreat request, level, active-high
sdata  output  W  current selector value
sel_oh  output  MAX+1  one-hot decode of sdata; bit sdata is set
step  output  1  high for exactly one cycle after each edge where sdata changed

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset: sync flops, debounced levels, debounce counters and edge registers all go to 0. Outputs reset to sdata=0, sel_oh=1 (bit 0 only), step=0.
- A line held high through reset counts as one rising edge after rst deasserts.
- Per line (N_IN+1 lines): 2-flop synchroniser feeding a debouncer.
  - Debouncer state: level db and counter cnt (8 bits).
  - Each edge where sync2 == db: cnt <= 0.
  - Each edge where sync2 != db and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - Each edge where sync2 != db and cnt == DB_CYCLES-1: db <= sync2 and cnt <= 0.
  - A pulse shorter than DB_CYCLES synchronised cycles is ignored entirely.
- Rising-edge detection: the registered pulse rise_x is set on the edge where db flips 0->1 and cleared on the next edge.
  - inc_req = OR of all en_in rise pulses. Several en_in rising on the same cycle produce one increment.
  - dec_req = dec_in rise pulse.
- Selector update, on the edge after a request pulse:
  - inc_req and not dec_req: sdata+1. At MAX: wrap to 0 (WRAP=1) or hold (WRAP=0).
  - dec_req and not inc_req: sdata-1. At 0: wrap to MAX (WRAP=1) or hold (WRAP=0).
  - Both or neither: hold.
- sel_oh is registered with sdata, so both change on the same edge.
- step is registered: it is 1 in the cycle following an edge where sdata actually changed. It stays 0 for saturated holds and for simultaneous inc/dec.
- Latency: raw input first sampled high at edge 0 and held stable gives
  - sync2 high after edge 1,
  - db flip at edge DB_CYCLES+1,
  - sdata update at edge DB_CYCLES+2,
  - step high during the following cycle.
  - With the defaults, sdata changes at edge 6.
- Falling edges never change sdata. Release debounce has the same DB_CYCLES rule, so a bounce during release cannot generate a new rise.
- Minimum spacing between accepted presses on one line: DB_CYCLES high plus DB_CYCLES low (synchronised cycles).
- Reset mid-operation: all pending debounce counts and edge pulses are discarded and sdata returns to 0 on that edge. No step is issued.
- The arithmetic is modulo-free. The next value is compared against MAX explicitly, so a non-power-of-two MAX (e.g. W=3, MAX=4) never reaches 5..7.

Test Plan:
- Defaults; en_in[0] held high from after edge 0 for 10 cycles -> sdata 0->1 at edge 6; step=1 for exactly one cycle; sel_oh=4'b0010.
- en_in[1] high for 3 synchronised cycles then low (glitch < DB_CYCLES) -> sdata stays 0, step never asserts.
- Four clean presses on en_in[0] with WRAP=1 -> sdata 1,2,3,0; sel_oh follows 0010,0100,1000,0001; four step pulses.
- WRAP=0, sdata=3, press en_in[0] -> sdata stays 3, no step. Then press dec_in from 0 after reset -> sdata stays 0, no step.
- en_in[0], en_in[1] and dec_in asserted together and held -> no change, no step. en_in[0] and en_in[1] together without dec_in -> exactly one increment.
- Press en_in[0] and assert rst for 1 cycle at edge 4 (mid-debounce) while the press continues -> sdata=0, step=0 after rst; increment lands at edge rst_release+DB_CYCLES+2 counted from the first post-reset sampling edge; W=3, MAX=4, WRAP=1 sweep wraps 4->0.
